// File: rtl/msdap_pkg.sv
// Shared constants and state encoding for the MSDAP output serializer.
package msdap_pkg;

    localparam int WORD_W = 40;
    localparam int CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic RST_OUT   = 1'b0;
    localparam logic RST_READY = 1'b1;

endpackage

// File: rtl/msdap_piso.sv
// WORD_W-bit load/shift register, LSB first, with a registered serial output
// that returns to 0 on any cycle it is not shifting.
module msdap_piso
    import msdap_pkg::*;
(
    input  logic              Sclk,
    input  logic              Reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              dout
);

    logic [WORD_W-1:0] sh;

    // On a reload edge the last bit of the old word leaves while the new word lands.
    always_ff @(posedge Sclk or negedge Reset) begin
        if (!Reset) begin
            sh   <= '0;
            dout <= RST_OUT;
        end else begin
            dout <= shift ? sh[0] : 1'b0;
            if (load)
                sh <= din;
            else if (shift)
                sh <= {1'b0, sh[WORD_W-1:1]};
        end
    end

endmodule

// File: rtl/msdap_out_serializer.sv
// MSDAP output serializer: one holding register feeding two PISOs, framed by OutReady.
// Optional sticky overrun flag enabled by defining MSDAP_OUT_OVERRUN_EN.
module msdap_out_serializer
    import msdap_pkg::*;
(
    input  logic              Sclk,
    input  logic              Reset,
    input  logic [WORD_W-1:0] res_l,
    input  logic [WORD_W-1:0] res_r,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              OutReady,
    output logic              OutputL,
    output logic              OutputR,
    output logic              overrun
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WORD_W-1:0] hold_l, hold_r;
    logic              hold_full, hold_full_nxt;
    logic              load, shift, hold_clr, accept, last;

    assign accept   = res_valid && res_ready;
    assign last     = (cnt == CNT_W'(WORD_W - 1));
    assign OutReady = (state == SEND);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift     = 1'b0;
        hold_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load      = 1'b1;
                    hold_clr  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                shift = 1'b1;
                if (!last) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (hold_full) begin
                    // Back-to-back word: reload without dropping OutReady.
                    load     = 1'b1;
                    hold_clr = 1'b1;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hold_full_nxt = accept | (hold_full & ~hold_clr);

    always_ff @(posedge Sclk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
            res_ready <= RST_READY;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hold_full <= hold_full_nxt;
            res_ready <= !hold_full_nxt;
            if (accept) begin
                hold_l <= res_l;
                hold_r <= res_r;
            end
        end
    end

    msdap_piso u_piso_l (
        .Sclk  (Sclk),
        .Reset (Reset),
        .load  (load),
        .shift (shift),
        .din   (hold_l),
        .dout  (OutputL)
    );

    msdap_piso u_piso_r (
        .Sclk  (Sclk),
        .Reset (Reset),
        .load  (load),
        .shift (shift),
        .din   (hold_r),
        .dout  (OutputR)
    );

`ifdef MSDAP_OUT_OVERRUN_EN
    logic overrun_q;

    // Producer still pushing while the last bit of a frame goes out with hold full.
    always_ff @(posedge Sclk or negedge Reset) begin
        if (!Reset)
            overrun_q <= 1'b0;
        else if (res_valid && !res_ready && state == SEND && last)
            overrun_q <= 1'b1;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Directed bench for msdap_out_serializer; expects overrun to set only when
// MSDAP_OUT_OVERRUN_EN is defined for the build.
module tb_msdap_out_serializer;

    logic        Sclk;
    logic        Reset;
    logic [39:0] res_l, res_r;
    logic        res_valid;
    logic        res_ready, OutReady, OutputL, OutputR, overrun;

    int          n_chk = 0;
    int          n_pass = 0;
    int          lat, orc, n_hold, k_bits;
    logic        bad;
    logic [39:0] cap_l [0:2];
    logic [39:0] cap_r [0:2];
    logic        exp_ovr;

    msdap_out_serializer dut (
        .Sclk      (Sclk),
        .Reset     (Reset),
        .res_l     (res_l),
        .res_r     (res_r),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .OutReady  (OutReady),
        .OutputL   (OutputL),
        .OutputR   (OutputR),
        .overrun   (overrun)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge Sclk);
        #1;
    endtask

    // Offer a word and return just after the edge that accepts it.
    task automatic send(input logic [39:0] l, input logic [39:0] r);
        int n;
        res_l = l;
        res_r = r;
        res_valid = 1'b1;
        n = 0;
        while (!res_ready && n < 100) begin
            tick;
            n++;
        end
        if (!res_ready) chk("send_timeout", 1'b0, 1'b1);
        tick;
        res_valid = 1'b0;
    endtask

    // Wait for the frame strobe, then capture nw words bit by bit.
    task automatic recv(input int nw, output int lt, output int oc);
        lt = 0;
        while (!OutReady && lt < 60) begin
            tick;
            lt++;
        end
        if (!OutReady) chk("frame_timeout", 1'b0, 1'b1);
        oc = 0;
        for (int w = 0; w < nw; w++)
            for (int k = 0; k < 40; k++) begin
                if (OutReady) oc++;
                tick;
                cap_l[w][k] = OutputL;
                cap_r[w][k] = OutputR;
            end
    endtask

    initial begin
`ifdef MSDAP_OUT_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        Reset = 1'b1;
        res_valid = 1'b0;
        res_l = '0;
        res_r = '0;
        #2 Reset = 1'b0;
        #1;
        chk("rst_outready", OutReady, 1'b0);
        chk("rst_outl", OutputL, 1'b0);
        chk("rst_outr", OutputR, 1'b0);
        chk("rst_ready", res_ready, 1'b1);
        chk("rst_overrun", overrun, 1'b0);
        repeat (3) tick;
        Reset = 1'b1;
        tick;

        // Single word: L bit0 only, R bit39 only.
        send(40'h00_0000_0001, 40'h80_0000_0000);
        chk("t1_ready_low", res_ready, 1'b0);
        recv(1, lat, orc);
        chk("t1_latency", lat, 1);
        chk("t1_outready_cycles", orc, 40);
        chk("t1_outready_end", OutReady, 1'b0);
        chk("t1_word_l", cap_l[0], 40'h00_0000_0001);
        chk("t1_word_r", cap_r[0], 40'h80_0000_0000);
        repeat (3) tick;

        // Three words back-to-back; third held off while hold is full.
        fork
            recv(3, lat, orc);
            begin
                send(40'h12_3456_789A, 40'hFE_DCBA_9876);
                send(40'hFE_DCBA_9876, 40'h12_3456_789A);
                chk("t2_ready_low", res_ready, 1'b0);
                res_l = 40'hC3_5A0F_F0A5;
                res_r = 40'h01_2345_6789;
                res_valid = 1'b1;
                n_hold = 0;
                while (!res_ready && n_hold < 100) begin
                    tick;
                    n_hold++;
                end
                chk("t3_holdoff_cycles", n_hold, 39);
                tick;
                res_valid = 1'b0;
                chk("t3_ready_low", res_ready, 1'b0);
            end
        join
        chk("t2_outready_cycles", orc, 120);
        chk("t2_outready_end", OutReady, 1'b0);
        chk("t2_w0_l", cap_l[0], 40'h12_3456_789A);
        chk("t2_w0_r", cap_r[0], 40'hFE_DCBA_9876);
        chk("t2_w1_l", cap_l[1], 40'hFE_DCBA_9876);
        chk("t2_w1_r", cap_r[1], 40'h12_3456_789A);
        chk("t3_w2_l", cap_l[2], 40'hC3_5A0F_F0A5);
        chk("t3_w2_r", cap_r[2], 40'h01_2345_6789);
        chk("t3_overrun", overrun, exp_ovr);
        repeat (5) tick;
        chk("t3_overrun_sticky", overrun, exp_ovr);

        // Reset mid-word after bit 10 has been driven.
        send(40'hAA_AAAA_AAAA, 40'h55_5555_5555);
        k_bits = 0;
        while (!OutReady && k_bits < 60) begin
            tick;
            k_bits++;
        end
        repeat (11) tick;
        chk("t4_bit10_r", OutputR, 1'b1);
        #3 Reset = 1'b0;
        #1;
        chk("t4_async_outready", OutReady, 1'b0);
        chk("t4_async_outl", OutputL, 1'b0);
        chk("t4_async_outr", OutputR, 1'b0);
        chk("t4_async_ready", res_ready, 1'b1);
        chk("t4_overrun_cleared", overrun, 1'b0);
        #1 Reset = 1'b1;
        tick;
        send(40'h00_0000_00FF, 40'h80_0000_00F0);
        recv(1, lat, orc);
        chk("t4_latency", lat, 1);
        chk("t4_word_l", cap_l[0], 40'h00_0000_00FF);
        chk("t4_word_r", cap_r[0], 40'h80_0000_00F0);

        // Idle: nothing offered for 100 cycles.
        bad = 1'b0;
        repeat (100) begin
            tick;
            bad = bad | OutReady | OutputL | OutputR;
        end
        chk("t5_idle_quiet", bad, 1'b0);
        chk("t5_idle_ready", res_ready, 1'b1);
        chk("t5_overrun", overrun, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/msdap_out_serializer.md
Name: msdap_out_serializer

Overview:
Output-side parallel-to-serial converter of the MSDAP. It accepts one 40-bit left/right result pair per handshake from the filter datapath. It drives the pair bit-serially, LSB first, on OutputL/OutputR, with the OutReady frame strobe, in the Sclk domain. One holding register absorbs a new result while the previous word is still shifting.

Parameters:
WORD_W, 40, width of each output word (L and R).
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WORD_W.

Ports:
Sclk  input  1  system/serial clock; all state on its rising edge.
Reset  input  1  asynchronous, active-low reset.
res_l  input  WORD_W  left result word.
res_r  input  WORD_W  right result word.
res_valid  input  1  res_l/res_r valid this cycle.
res_ready  output  1  holding register empty; transfer on res_valid && res_ready.
OutReady  output  1  frame strobe; high for exactly WORD_W cycles per word.
OutputL  output  1  left serial data.
OutputR  output  1  right serial data.
overrun  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset low (async):
  - OutReady=0, OutputL=0, OutputR=0, overrun=0, res_ready=1.
  - Holding register and shift registers cleared, bit counter=0, state=IDLE.
  - Reset asserted mid-word aborts the word with no residual bits. The first word accepted after release starts a clean frame.
- Interface: clock and reset are the single Sclk and the active-low Reset. Reset is asynchronous, and this is fixed.
- Storage: holding register (hold_l, hold_r, hold_full) plus shift registers (sh_l, sh_r). res_ready = !hold_full, registered.
- Accept: at an edge where res_valid && res_ready, hold <= {res_l,res_r} and hold_full <= 1.
- States:
  - IDLE: OutReady=0. At the first edge where hold_full=1: sh <= hold, hold_full <= 0, cnt <= 0, go to SEND.
  - SEND: OutReady=1 for window cycles i=0..WORD_W-1 (cnt=i). At the edge closing cycle i: OutputL <= sh_l[i], OutputR <= sh_r[i], cnt <= cnt+1.
  - Leaving SEND: at the edge closing i=WORD_W-1, if hold_full then reload sh from hold, cnt <= 0 and stay in SEND (OutReady stays high, no gap). Otherwise go to IDLE.
- Timing:
  - OutReady leads data by one Sclk cycle. If OutReady rises at edge E0, bit k is driven at edge E0+1+k and is stable for one full cycle.
  - A consumer that registers OutReady once and samples while the registered copy is high captures exactly bits 0..39.
- Idle output: at any edge not closing a window cycle, OutputL/OutputR <= 0.
- Latency: word accepted at edge A into an idle block gives OutReady high after A+1, bit0 after A+2, bit39 after A+41.
- Simultaneous events: accept and hold->shift transfer on the same edge is legal. Transfer empties hold; accept refills it; hold_full ends 1.
- res_valid while res_ready=0 leaves the data unaccepted, with no corruption.

Optional Feature:
Macro MSDAP_OUT_OVERRUN_EN.
- Defined: overrun sets (sticky until Reset) at any edge where res_valid=1, res_ready=0 and state=SEND with cnt=WORD_W-1. This flags a producer that failed to hold off through a full frame.
- Undefined: overrun tied to 0 and no extra logic is generated.

Decomposition:
- Package msdap_pkg: WORD_W=40, CNT_W=6, state enum {IDLE, SEND}, reset-value constants.
- One natural sub-module: msdap_piso, a WORD_W-bit load/shift register with a 1-bit registered output, instantiated twice (L, R). It shares the counter and FSM in the parent.

Test Plan:
- Single word L=40'h00_0000_0001, R=40'h80_0000_0000 accepted at edge A:
  - OutReady high edges A+1..A+40.
  - OutputL=1 only in bit0 slot.
  - OutputR=1 only in bit39 slot.
  - Sampled 40-bit words match exactly.
- Two words 40'h12_3456_789A / 40'hFE_DCBA_9876 offered back-to-back:
  - OutReady continuously high 80 cycles.
  - Both word pairs recovered in order.
  - res_ready low from second accept until first word's last bit.
- Third word offered while hold full and SEND mid-word: res_ready=0, word held off, then accepted on the edge hold empties, with no data loss.
- Reset asserted after bit 10 of word 40'hAA_AAAA_AAAA:
  - OutReady/OutputL/OutputR=0 immediately (async).
  - res_ready=1.
  - Next word 40'h00_0000_00FF serializes correctly from bit0.
- Idle check: no word offered for 100 cycles -> OutReady=0 and OutputL/OutputR=0 throughout.
- With MSDAP_OUT_OVERRUN_EN: res_valid held high while blocked at cnt=39 -> overrun=1 and stays 1 until Reset. Without the macro, overrun=0 always.
